frog_motion_ctrl: RTL and testbench



---
 rtl/frogger_pkg.sv | 25 ++
 rtl/frog_motion_ctrl.sv | 175 +++++++++++++++++
 tb/tb_frog_motion_ctrl.sv | 204 ++++++++++++++++++++
 3 files changed

// File: rtl/frogger_pkg.sv
// Shared types and constants for the Frogger datapath.
// Holds the frog FSM state encoding, grid defaults and the score helper.
package frogger_pkg;

  typedef enum logic [1:0] {
    ST_READY = 2'd0,
    ST_HOP   = 2'd1,
    ST_DEATH = 2'd2,
    ST_OVER  = 2'd3
  } frog_state_t;

  localparam int GRID_COLS_DEF = 16;
  localparam int GRID_ROWS_DEF = 12;
  localparam int SCORE_W       = 8;
  localparam int LIVES_W       = 3;

  // Score add that clamps at the all-ones value instead of wrapping.
  function automatic logic [SCORE_W-1:0] sat_add(input logic [SCORE_W-1:0] a,
                                                 input logic [SCORE_W-1:0] b);
    logic [SCORE_W:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    return sum[SCORE_W] ? {SCORE_W{1'b1}} : sum[SCORE_W-1:0];
  endfunction

endpackage

// File: rtl/frog_motion_ctrl.sv
// Frog position, hop cooldown, death/respawn, lives and score controller.
// One FSM with a single down-counter shared between HOP and DEATH.
module frog_motion_ctrl
  import frogger_pkg::*;
#(
  parameter int GRID_COLS    = GRID_COLS_DEF,
  parameter int GRID_ROWS    = GRID_ROWS_DEF,
  parameter int START_COL    = 7,
  parameter int HOP_CYCLES   = 8,
  parameter int DEATH_CYCLES = 32,
  parameter int LIVES        = 3,
  parameter int GOAL_BONUS   = 10
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         forwardPulse,
  input  logic                         backwardPulse,
  input  logic                         rightPulse,
  input  logic                         leftPulse,
  input  logic                         kill,
  output logic [$clog2(GRID_COLS)-1:0] frog_col,
  output logic [$clog2(GRID_ROWS)-1:0] frog_row,
  output logic                         hopping,
  output logic                         dying,
  output logic                         game_over,
  output logic                         goal_pulse,
  output logic [LIVES_W-1:0]           lives_left,
  output logic [SCORE_W-1:0]           score
);

  localparam int COL_W    = $clog2(GRID_COLS);
  localparam int ROW_W    = $clog2(GRID_ROWS);
  localparam int MAX_CYC  = (HOP_CYCLES > DEATH_CYCLES) ? HOP_CYCLES : DEATH_CYCLES;
  localparam int CNT_W    = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

  localparam logic [COL_W-1:0]   MAX_COL    = COL_W'(GRID_COLS - 1);
  localparam logic [ROW_W-1:0]   MAX_ROW    = ROW_W'(GRID_ROWS - 1);
  localparam logic [COL_W-1:0]   SPAWN_COL  = COL_W'(START_COL);
  localparam logic [CNT_W-1:0]   HOP_LOAD   = CNT_W'(HOP_CYCLES - 1);
  localparam logic [CNT_W-1:0]   DEATH_LOAD = CNT_W'(DEATH_CYCLES - 1);
  localparam logic [LIVES_W-1:0] LIVES_INIT = LIVES_W'(LIVES);
  localparam logic [SCORE_W-1:0] BONUS      = SCORE_W'(GOAL_BONUS);

  frog_state_t        r_state;
  logic [CNT_W-1:0]   r_cnt;
  logic [COL_W-1:0]   r_col;
  logic [ROW_W-1:0]   r_row;
  logic [ROW_W-1:0]   r_best_row;
  logic [LIVES_W-1:0] r_lives;
  logic [SCORE_W-1:0] r_score;
  logic               r_hopping;
  logic               r_dying;
  logic               r_game_over;
  logic               r_goal_pulse;

  logic               w_move_ok;
  logic [COL_W-1:0]   w_new_col;
  logic [ROW_W-1:0]   w_new_row;

  // Only the highest-priority strobe is considered; if it points off-grid
  // the cycle is a no-op rather than falling through to a lower strobe.
  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    w_move_ok = 1'b0;
    w_new_col = r_col;
    w_new_row = r_row;
    if (forwardPulse) begin
      w_new_row = r_row + ROW_W'(1);
      w_move_ok = (r_row != MAX_ROW);
    end else if (backwardPulse) begin
      w_new_row = r_row - ROW_W'(1);
      w_move_ok = (r_row != '0);
    end else if (leftPulse) begin
      w_new_col = r_col - COL_W'(1);
      w_move_ok = (r_col != '0);
    end else if (rightPulse) begin
      w_new_col = r_col + COL_W'(1);
      w_move_ok = (r_col != MAX_COL);
    end
  end

  // NOTE: all state below uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= ST_READY;
      r_cnt        <= '0;
      r_col        <= SPAWN_COL;
      r_row        <= '0;
      r_best_row   <= '0;
      r_lives      <= LIVES_INIT;
      r_score      <= '0;
      r_hopping    <= 1'b0;
      r_dying      <= 1'b0;
      r_game_over  <= 1'b0;
      r_goal_pulse <= 1'b0;
    end else begin
      r_goal_pulse <= 1'b0;
      case (r_state)
        ST_READY, ST_HOP: begin
          if (kill) begin
            // Position is left untouched so the renderer shows where the frog died.
            r_state   <= ST_DEATH;
            r_hopping <= 1'b0;
            r_dying   <= 1'b1;
            r_cnt     <= DEATH_LOAD;
            if (r_lives != '0) r_lives <= r_lives - LIVES_W'(1);
          end else if (r_state == ST_READY) begin
            if (w_move_ok) begin
              r_col     <= w_new_col;
              r_row     <= w_new_row;
              r_state   <= ST_HOP;
              r_hopping <= 1'b1;
              r_cnt     <= HOP_LOAD;
              if (w_new_row > r_best_row) begin
                r_best_row <= w_new_row;
                r_score    <= sat_add(r_score, SCORE_W'(1));
              end
            end
          end else if (r_cnt == '0) begin
            r_state   <= ST_READY;
            r_hopping <= 1'b0;
            if (r_row == MAX_ROW) begin
              r_goal_pulse <= 1'b1;
              r_score      <= sat_add(r_score, BONUS);
              r_col        <= SPAWN_COL;
              r_row        <= '0;
              r_best_row   <= '0;
            end
          end else begin
            r_cnt <= r_cnt - CNT_W'(1);
          end
        end
        ST_DEATH: begin
          if (r_cnt == '0) begin
            r_dying <= 1'b0;
            if (r_lives == '0) begin
              r_state     <= ST_OVER;
              r_game_over <= 1'b1;
            end else begin
              r_state    <= ST_READY;
              r_col      <= SPAWN_COL;
              r_row      <= '0;
              r_best_row <= '0;
            end
          end else begin
            r_cnt <= r_cnt - CNT_W'(1);
          end
        end
        ST_OVER: begin
          if (forwardPulse) begin
            r_state     <= ST_READY;
            r_game_over <= 1'b0;
            r_col       <= SPAWN_COL;
            r_row       <= '0;
            r_best_row  <= '0;
            r_lives     <= LIVES_INIT;
            r_score     <= '0;
          end
        end
        default: r_state <= ST_READY;
      endcase
    end
  end

  assign frog_col   = r_col;
  assign frog_row   = r_row;
  assign hopping    = r_hopping;
  assign dying      = r_dying;
  assign game_over  = r_game_over;
  assign goal_pulse = r_goal_pulse;
  assign lives_left = r_lives;
  assign score      = r_score;

endmodule

// File: tb/tb_frog_motion_ctrl.sv
// Directed self-checking bench for frog_motion_ctrl with default parameters.
module tb_frog_motion_ctrl;
  import frogger_pkg::*;

  logic       clk = 1'b0;
  logic       reset;
  logic       forwardPulse, backwardPulse, rightPulse, leftPulse, kill;
  logic [3:0] frog_col, frog_row;
  logic       hopping, dying, game_over, goal_pulse;
  logic [2:0] lives_left;
  logic [7:0] score;

  int checks = 0;
  int errors = 0;
  int n;

  frog_motion_ctrl dut (
    .clk          (clk),
    .reset        (reset),
    .forwardPulse (forwardPulse),
    .backwardPulse(backwardPulse),
    .rightPulse   (rightPulse),
    .leftPulse    (leftPulse),
    .kill         (kill),
    .frog_col     (frog_col),
    .frog_row     (frog_row),
    .hopping      (hopping),
    .dying        (dying),
    .game_over    (game_over),
    .goal_pulse   (goal_pulse),
    .lives_left   (lives_left),
    .score        (score)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Outputs are sampled 1 time unit after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic strobe(input logic f, input logic b, input logic l, input logic r, input logic k);
    forwardPulse = f; backwardPulse = b; leftPulse = l; rightPulse = r; kill = k;
    step();
    forwardPulse = 0; backwardPulse = 0; leftPulse = 0; rightPulse = 0; kill = 0;
  endtask

  // Counts consecutive hopping cycles (start = cycles already seen); ends on first non-HOP cycle.
  task automatic wait_hop(input int start, output int cnt);
    int guard = 0;
    cnt = start;
    while (hopping && guard < 100) begin
      step();
      guard++;
      if (hopping) cnt++;
    end
  endtask

  task automatic wait_death(output int cnt);
    int guard = 0;
    cnt = dying ? 1 : 0;
    while (dying && guard < 200) begin
      step();
      guard++;
      if (dying) cnt++;
    end
  endtask

  task automatic hop(input logic f, input logic b, input logic l, input logic r, output int cnt);
    strobe(f, b, l, r, 1'b0);
    wait_hop(hopping ? 1 : 0, cnt);
  endtask

  task automatic check_pos(input string tag, input int col, input int row);
    check({tag, "_col"}, frog_col, col);
    check({tag, "_row"}, frog_row, row);
  endtask

  // Eleven forward hops from spawn; returns on the first READY cycle after the goal.
  task automatic goal_run();
    int c;
    for (int i = 0; i < 11; i++) hop(1, 0, 0, 0, c);
  endtask

  task automatic check_reset_vals(input string tag);
    check_pos(tag, 7, 0);
    check({tag, "_lives"}, lives_left, 3);
    check({tag, "_score"}, score, 0);
    check({tag, "_flags"}, {hopping, dying, game_over, goal_pulse}, 0);
  endtask

  initial begin
    reset = 1; forwardPulse = 0; backwardPulse = 0; rightPulse = 0; leftPulse = 0; kill = 0;
    #12;
    check_reset_vals("reset");
    @(negedge clk) reset = 0;

    // Basic hop with an ignored strobe during cooldown
    strobe(1, 0, 0, 0, 0);
    check_pos("hop1", 7, 1);
    check("hop1_hopping", hopping, 1);
    check("hop1_score", score, 1);
    strobe(1, 0, 0, 0, 0);
    check_pos("hop_ignored", 7, 1);
    wait_hop(2, n);
    check("hop_len", n, 8);
    check_pos("hop_after", 7, 1);
    check("hop_after_score", score, 1);

    // Left edge clamp
    for (int i = 0; i < 7; i++) hop(0, 0, 1, 0, n);
    check_pos("clamp7", 0, 1);
    strobe(0, 0, 1, 0, 0);
    check_pos("clamp8", 0, 1);
    check("clamp8_hopping", hopping, 0);
    hop(0, 0, 0, 1, n);
    check_pos("right", 1, 1);
    check("right_len", n, 8);

    // Priority: forward beats left
    strobe(1, 0, 1, 0, 0);
    check_pos("prio_fwd_left", 1, 2);
    check("prio_score", score, 2);
    wait_hop(1, n);
    hop(0, 1, 0, 0, n);
    check_pos("back", 1, 1);
    check("back_score", score, 2);

    // Kill beats forward
    strobe(1, 0, 0, 0, 1);
    check("kill_dying", dying, 1);
    check("kill_hopping", hopping, 0);
    check_pos("kill_frozen", 1, 1);
    check("kill_lives", lives_left, 2);
    wait_death(n);
    check("death_len", n, 32);
    check_pos("respawn", 7, 0);
    check("respawn_lives", lives_left, 2);

    // Goal run from a fresh game
    reset = 1; #1; reset = 0;
    for (int i = 0; i < 10; i++) hop(1, 0, 0, 0, n);
    strobe(1, 0, 0, 0, 0);
    check_pos("goal_top", 7, 11);
    check("goal_pulse_early", goal_pulse, 0);
    wait_hop(1, n);
    check("goal_pulse", goal_pulse, 1);
    check("goal_score", score, 21);
    check_pos("goal_spawn", 7, 0);
    step();
    check("goal_pulse_one_cycle", goal_pulse, 0);

    // Game over and restart
    for (int k = 0; k < 3; k++) begin
      strobe(0, 0, 0, 0, 1);
      check("go_lives", lives_left, 2 - k);
      wait_death(n);
    end
    check("go_game_over", game_over, 1);
    check("go_lives_zero", lives_left, 0);
    strobe(0, 0, 0, 0, 1);
    check("go_kill_ignored", {game_over, dying, lives_left}, {1'b1, 1'b0, 3'd0});
    strobe(0, 0, 1, 0, 0);
    check("go_left_ignored", {game_over, frog_col}, {1'b1, 4'd7});
    strobe(1, 0, 0, 0, 0);
    check("restart_over", game_over, 0);
    check("restart_hopping", hopping, 0);
    check_pos("restart", 7, 0);
    check("restart_lives", lives_left, 3);
    check("restart_score", score, 0);

    // Asynchronous reset during DEATH
    hop(1, 0, 0, 0, n);
    strobe(0, 0, 0, 0, 1);
    step();
    step();
    check("mid_death_dying", dying, 1);
    #2 reset = 1;
    #1;
    check_reset_vals("async_reset");
    @(negedge clk) reset = 0;

    // Score saturation
    for (int g = 0; g < 12; g++) goal_run();
    check("sat_252", score, 252);
    goal_run();
    check("sat_255", score, 255);
    hop(1, 0, 0, 0, n);
    check("sat_hold", score, 255);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
